interrupt_priority_encoder: RTL and testbench
=============================================

// Module: interrupt_priority_encoder
// PURPOSE
//  Encoder side of the interrupt map: collapses 16 one-hot interrupt lines into
//  one 4-bit interrupt ID for the control unit. It is the inverse of the 4->16
//  memory-map decoder. Captures rising edges into a pending register and applies
//  an enable mask. Presents the lowest-numbered enabled pending line and holds it
//  until the CPU acknowledges. Sits between peripheral IRQ lines and the control FSM.
// PARAMETERS
//  NUM_IRQ   16   number of interrupt lines (fixed at 16 for this block)
//  ID_W      4    width of irq_id, log2(NUM_IRQ)
// PORTS
//  CLK          in   1        system clock, all state updates on rising edge
//  RST          in   1        synchronous, active-high reset
//  irq_in       in   16       raw interrupt lines, level; rising edge = request
//  mask_we      in   1        write enable for the mask register
//  mask_in      in   16       new mask value; bit=1 enables that line
//  mask_out     out  16       current mask register
//  pending_out  out  16       current pending register
//  irq_req      out  1        request to CPU; high while an ID is presented
//  irq_id       out  4        ID being presented; valid only while irq_req=1
//  irq_ack      in   1        CPU acknowledge of the presented ID
// BEHAVIOUR
//  Reset (RST=1 at a clock edge):
//  - pending=0, mask=16'h0000, irq_req=0, irq_id=0, state=IDLE.
//  - irq_q<=irq_in, so lines held high across reset raise no edge afterwards.
//  Edge capture, every cycle:
//  - edge = irq_in & ~irq_q; irq_q<=irq_in.
//  - pending <= (pending & ~clr) | edge. clr is the one-hot bit of irq_id on ack.
//  - Set wins over clear: an ack and a new edge on the same bit leave it pending.
//  - A level held high sets its bit once; it is not re-armed until it drops.
//  - Edges on masked lines still set pending; the mask only gates selection.
//  Mask: mask_we=1 -> mask<=mask_in at that edge. Visible to selection the next cycle.
//  FSM (2 states):
//  - IDLE: irq_req=0.
//    - If |(pending & mask): irq_id <= lowest set index, irq_req<=1, go to PRESENT.
//    - irq_ack is ignored in IDLE.
//  - PRESENT: irq_req=1, irq_id held stable.
//    - Unmasking or new edges on higher-priority lines do not change irq_id.
//    - Masking the presented line does not retract the request.
//    - On irq_ack=1: clear pending[irq_id], irq_req<=0, go to IDLE.
//  Latency:
//  - irq_in rises before edge k -> pending bit set at edge k -> irq_req high after edge k+1.
//  - After an ack, the next request is presented no sooner than 2 edges later
//    (at least one idle cycle between requests).
//  Priority: index 0 highest, 15 lowest, fixed.
//  RST mid-PRESENT: request dropped, pending and mask cleared, no ack needed.
//  irq_id holds its last value in IDLE; consumers must qualify it with irq_req.
// STRUCTURE
//  - Shared include interrupt_defs.vh:
//    - NUM_IRQ, ID_W.
//    - FSM state codes ST_IDLE=1'b0, ST_PRESENT=1'b1.
//    - Shared with the memory-map decoder and the control FSM.
//  - One sub-module, priority_encoder_16: combinational, 16-bit in ->
//    {valid, 4-bit lowest set index}. The top level holds all registers and the FSM.
// TESTING
//  1 Reset and mask write:
//    - Hold RST 2 cycles -> irq_req=0, pending_out=0, mask_out=0.
//    - mask_we, mask_in=16'hFFFF -> mask_out=16'hFFFF next cycle.
//  2 Single request:
//    - Pulse irq_in[5] -> irq_req=1, irq_id=5 two edges later.
//    - Assert irq_ack 1 cycle -> irq_req=0, pending_out=0.
//  3 Priority:
//    - Set irq_in 16'h8011 in one cycle -> ids presented in order 0, 4, 15,
//      each after an ack, with one idle cycle between.
//  4 Masking:
//    - mask=16'hFFF7, pulse irq_in[3] -> irq_req stays 0, pending_out[3]=1.
//    - Write mask=16'hFFFF -> irq_id=3 presented.
//  5 Set-over-clear and level hold:
//    - Hold irq_in[2] high, ack ID 2 -> no re-request.
//    - Drop irq_in[2], re-raise it on the ack cycle -> pending_out[2] stays 1,
//      ID 2 presented again.
//  6 Reset mid-operation:
//    - Present ID 7, assert RST 1 cycle with irq_in[7] still high ->
//      irq_req=0 and no request afterwards.

Source files
------------

// File: rtl/interrupt_priority_encoder_pkg.sv
// Shared constants and FSM state codes for the interrupt map
// (used by the encoder, the memory-map decoder and the control FSM).
package interrupt_priority_encoder_pkg;
    localparam int NUM_IRQ = 16;
    localparam int ID_W    = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;
endpackage

// File: rtl/interrupt_priority_encoder_penc.sv
// Combinational 16-line priority encoder: reports whether any bit is set and
// the index of the lowest set bit (bit 0 has the highest priority).
module priority_encoder_16
    import interrupt_priority_encoder_pkg::*;
(
    input  logic [NUM_IRQ-1:0] i_vec,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_idx
);

    always_comb begin
        o_valid = |i_vec;
        o_idx   = '0;
        // Walk from the top so the lowest set index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = ID_W'(i);
        end
    end

endmodule

// File: rtl/interrupt_priority_encoder.sv
// Captures IRQ rising edges into a pending register, gates them with a mask and
// presents the lowest-numbered enabled pending line to the CPU until acknowledged.
module interrupt_priority_encoder
    import interrupt_priority_encoder_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_in,
    output logic [NUM_IRQ-1:0] mask_out,
    output logic [NUM_IRQ-1:0] pending_out,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack
);

    state_t               r_state;
    logic [NUM_IRQ-1:0]   r_irq_q;
    logic [NUM_IRQ-1:0]   r_pending;
    logic [NUM_IRQ-1:0]   r_mask;
    logic [ID_W-1:0]      r_id;

    state_t               w_state_nxt;
    logic [ID_W-1:0]      w_id_nxt;
    logic [NUM_IRQ-1:0]   w_edge;
    logic [NUM_IRQ-1:0]   w_clr;
    logic                 w_sel_valid;
    logic [ID_W-1:0]      w_sel_idx;

    assign w_edge = irq_in & ~r_irq_q;

    priority_encoder_16 u_penc (
        .i_vec   (r_pending & r_mask),
        .o_valid (w_sel_valid),
        .o_idx   (w_sel_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_clr       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_state_nxt = ST_PRESENT;
                    w_id_nxt    = w_sel_idx;
                end
            end
            ST_PRESENT: begin
                if (irq_ack) begin
                    w_state_nxt  = ST_IDLE;
                    w_clr[r_id]  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // irq_q follows irq_in even in reset so held-high lines raise no edge later.
        r_irq_q <= irq_in;
        if (RST) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_mask    <= '0;
            r_id      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_id      <= w_id_nxt;
            // Set wins over clear on the same bit.
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (mask_we) r_mask <= mask_in;
        end
    end

    assign irq_req     = (r_state == ST_PRESENT);
    assign irq_id      = r_id;
    assign mask_out    = r_mask;
    assign pending_out = r_pending;

endmodule

// File: tb/tb_interrupt_priority_encoder.sv
// Bench for interrupt_priority_encoder: directed scenarios with literal
// expectations, then random traffic checked every cycle against a behavioural model.
module tb_interrupt_priority_encoder;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] irq_in;
    logic        mask_we;
    logic [15:0] mask_in;
    logic [15:0] mask_out;
    logic [15:0] pending_out;
    logic        irq_req;
    logic [3:0]  irq_id;
    logic        irq_ack;

    int checks = 0;
    int errors = 0;

    interrupt_priority_encoder dut (
        .CLK         (CLK),
        .RST         (RST),
        .irq_in      (irq_in),
        .mask_we     (mask_we),
        .mask_in     (mask_in),
        .mask_out    (mask_out),
        .pending_out (pending_out),
        .irq_req     (irq_req),
        .irq_id      (irq_id),
        .irq_ack     (irq_ack)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: set of pending lines, mask, and the currently presented id.
    logic [15:0] m_pend, m_mask, m_prev;
    bit          m_req;
    int          m_id;
    bit          chk_en = 1'b0;

    always @(posedge CLK) begin
        logic [15:0] nxt;
        if (RST) begin
            m_pend = '0; m_mask = '0; m_req = 1'b0; m_id = 0;
        end else begin
            nxt = m_pend;
            if (m_req && irq_ack) nxt[m_id] = 1'b0;
            for (int i = 0; i < 16; i++)
                if (irq_in[i] && !m_prev[i]) nxt[i] = 1'b1;
            if (!m_req) begin
                for (int i = 15; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) begin m_req = 1'b1; m_id = i; end
            end else if (irq_ack) begin
                m_req = 1'b0;
            end
            if (mask_we) m_mask = mask_in;
            m_pend = nxt;
        end
        m_prev = irq_in;
        chk_en = 1'b1;
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_req",  {31'd0, irq_req}, {31'd0, m_req});
            chk("model_pend", {16'd0, pending_out}, {16'd0, m_pend});
            chk("model_mask", {16'd0, mask_out}, {16'd0, m_mask});
            if (m_req) chk("model_id", {28'd0, irq_id}, m_id);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic ack_once();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    initial begin
        RST = 1'b1; irq_in = '0; mask_we = 1'b0; mask_in = '0; irq_ack = 1'b0;
        tick(); tick();
        RST = 1'b0;
        chk("rst_req",  {31'd0, irq_req}, 32'd0);
        chk("rst_pend", {16'd0, pending_out}, 32'd0);
        chk("rst_mask", {16'd0, mask_out}, 32'd0);

        mask_we = 1'b1; mask_in = 16'hFFFF; tick(); mask_we = 1'b0;
        chk("mask_wr", {16'd0, mask_out}, 32'hFFFF);

        // Single request on line 5.
        irq_in = 16'h0020; tick(); irq_in = '0;
        chk("single_pend", {16'd0, pending_out}, 32'h0020);
        chk("single_req_lat", {31'd0, irq_req}, 32'd0);
        tick();
        chk("single_req", {31'd0, irq_req}, 32'd1);
        chk("single_id",  {28'd0, irq_id}, 32'd5);
        ack_once();
        chk("single_ack_req",  {31'd0, irq_req}, 32'd0);
        chk("single_ack_pend", {16'd0, pending_out}, 32'd0);

        // Priority order 0, 4, 15 with an idle cycle between.
        irq_in = 16'h8011; tick(); irq_in = '0; tick();
        chk("prio_id0", {28'd0, irq_id}, 32'd0);
        ack_once();
        chk("prio_gap0", {31'd0, irq_req}, 32'd0);
        tick();
        chk("prio_id4", {28'd0, irq_id}, 32'd4);
        ack_once();
        chk("prio_gap4", {31'd0, irq_req}, 32'd0);
        tick();
        chk("prio_req15", {31'd0, irq_req}, 32'd1);
        chk("prio_id15", {28'd0, irq_id}, 32'd15);
        ack_once();

        // Masked line stays pending until unmasked.
        mask_we = 1'b1; mask_in = 16'hFFF7; tick(); mask_we = 1'b0;
        irq_in = 16'h0008; tick(); irq_in = '0; tick(); tick();
        chk("mask_req",  {31'd0, irq_req}, 32'd0);
        chk("mask_pend", {31'd0, pending_out[3]}, 32'd1);
        mask_we = 1'b1; mask_in = 16'hFFFF; tick(); mask_we = 1'b0;
        tick();
        chk("unmask_req", {31'd0, irq_req}, 32'd1);
        chk("unmask_id",  {28'd0, irq_id}, 32'd3);
        ack_once();

        // Level held high does not re-request.
        irq_in = 16'h0004; tick(); tick();
        chk("lvl_id", {28'd0, irq_id}, 32'd2);
        ack_once(); tick(); tick();
        chk("lvl_norereq", {31'd0, irq_req}, 32'd0);
        chk("lvl_pend",    {16'd0, pending_out}, 32'd0);
        // Present 2 again, then ack on the same cycle as a fresh edge.
        irq_in = '0; tick(); irq_in = 16'h0004; tick(); tick();
        chk("soc_pre_id", {28'd0, irq_id}, 32'd2);
        irq_in = '0; tick();
        irq_in = 16'h0004; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("soc_pend", {31'd0, pending_out[2]}, 32'd1);
        chk("soc_gap",  {31'd0, irq_req}, 32'd0);
        tick();
        chk("soc_req", {31'd0, irq_req}, 32'd1);
        chk("soc_id",  {28'd0, irq_id}, 32'd2);
        ack_once();

        // Reset mid-present with the line still high.
        irq_in = 16'h0080; tick(); tick();
        chk("rstmid_id", {28'd0, irq_id}, 32'd7);
        RST = 1'b1; tick(); RST = 1'b0;
        chk("rstmid_req",  {31'd0, irq_req}, 32'd0);
        chk("rstmid_pend", {16'd0, pending_out}, 32'd0);
        mask_we = 1'b1; mask_in = 16'hFFFF; tick(); mask_we = 1'b0;
        tick(); tick();
        chk("rstmid_noreq", {31'd0, irq_req}, 32'd0);
        irq_in = '0;

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            irq_in  = irq_in ^ 16'($urandom & $urandom & $urandom);
            irq_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            mask_we = ($urandom_range(0, 19) == 0);
            mask_in = 16'($urandom | $urandom);
            RST     = ($urandom_range(0, 299) == 0);
            tick();
        end
        RST = 1'b0; irq_ack = 1'b0; mask_we = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
